if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch front end that produces the {pc4, inst} pair consumed by the IF/ID pipeline register. It owns the PC, runs a req/ack handshake to instruction memory, and holds a fetched instruction until the stage is allowed to advance (nostall=1). It also accepts branch/jump redirects from ID and squashes any fetch still in flight. When no valid instruction is held, it presents a NOP so the IF/ID register captures a bubble.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset (word aligned).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
nostall  input  1  from hazard unit; same signal as the IF/ID write enable; 1 = held instruction is consumed this edge.
redirect  input  1  branch/jump taken, from ID.
redirect_pc  input  32  redirect target.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address = current PC.
imem_ack  input  1  imem_rdata is valid this cycle.
imem_rdata  input  32  fetched instruction word.
pc4  output  32  PC+4 of the held instruction; drives the IF/ID register.
inst  output  32  held instruction, or 32'h0 (NOP) when inst_valid=0.
inst_valid  output  1  a real instruction is being presented.
fetch_busy  output  1  1 in FETCH or KILL.
fetch_err  output  1  misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset (rst=0 at edge):
  - pc=RESET_PC, state=FETCH, inst_buf=0, pc4_buf=RESET_PC+4, inst_valid=0, fetch_err=0, pending target=0.
  - Registered outputs take these values on the first edge with rst=0.
  - Reset overrides every other input.
  - Instruction memory shares rst, so no stale ack is delivered after reset.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - READY: imem_req=0, inst_valid=1.
  - KILL: imem_req=1, imem_addr=pc; the outstanding result will be discarded.
- Handshake rules:
  - While imem_req=1 and imem_ack=0, imem_addr must not change.
  - A request completes on the edge where imem_ack=1.
  - Zero-wait acks (ack in the first cycle of req) are legal.
- FETCH transitions:
  - ack=1, redirect=0: inst_buf<=imem_rdata, pc4_buf<=pc+4, go to READY.
  - ack=1, redirect=1: drop rdata, pc<=redirect_pc, stay in FETCH.
  - ack=0, redirect=1: tgt<=redirect_pc, go to KILL.
  - ack=0, redirect=0: stay in FETCH.
- KILL transitions:
  - ack=1: drop rdata. pc<=tgt, or redirect_pc if a new redirect is asserted this cycle. Go to FETCH.
  - ack=0, redirect=1: tgt<=redirect_pc (newest redirect wins).
- READY transitions:
  - redirect=1: pc<=redirect_pc, inst_valid<=0, go to FETCH. Redirect wins over nostall; the held instruction is still captured by IF/ID if nostall=1 that edge, and ID is responsible for flushing it.
  - redirect=0, nostall=1: pc<=pc+4, inst_valid<=0, go to FETCH.
  - redirect=0, nostall=0: hold all state and outputs.
- Output rules:
  - pc4 = pc4_buf at all times.
  - inst = inst_valid ? inst_buf : 32'h0.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Throughput: 2 cycles per instruction with zero-wait memory, plus N cycles for N wait states.
- nostall in FETCH/KILL: no effect on state. The IF/ID register captures a NOP bubble.

Optional Feature:
Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 (in any state) sets fetch_err=1; it stays set until reset.
  - State goes to HALT: imem_req=0, inst_valid=0, nothing accepted until reset.
  - A misaligned redirect arriving while in FETCH/KILL with a request outstanding waits for the ack, then enters HALT.
- Undefined:
  - redirect_pc[1:0] are forced to 2'b00 before use.
  - fetch_err is tied to 0.
  - There is no HALT state.

Test Plan:
- Reset release, zero-wait memory returning 32'h2008_0005 at 32'h0040_0000, nostall=1 -> imem_addr 32'h0040_0000; one cycle later inst=32'h2008_0005, pc4=32'h0040_0004, inst_valid=1; next request at 32'h0040_0004.
- 3 wait states, nostall=1 -> inst_valid=0 and inst=0 for 4 cycles; imem_addr stable throughout; the instruction appears the cycle after the ack.
- READY with nostall=0 for 5 cycles -> inst/pc4/inst_valid unchanged and imem_req=0; on nostall=1, pc advances by 4.
- Redirect to 32'h0040_0100 while in FETCH without ack, ack 2 cycles later with data 32'hDEAD_BEEF -> data discarded (never valid); next imem_addr=32'h0040_0100.
- pc=32'hFFFF_FFFC fetch consumed -> next imem_addr=32'h0000_0000, pc4 of that instruction = 32'h0000_0000.
- FETCH_ALIGN_CHK_EN defined, redirect_pc=32'h0040_0102 -> fetch_err=1, imem_req=0 until rst=0; macro undefined -> next imem_addr=32'h0040_0100.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, runs a req/ack handshake to imem, holds one instruction for IF/ID (2 cycles/inst at zero wait).
// Defining FETCH_ALIGN_CHK_EN traps misaligned redirects into a sticky HALT; otherwise redirect_pc[1:0] are cleared.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nostall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fetch_busy,
  output logic        fetch_err
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_KILL  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] pc4_buf_q, pc4_buf_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] rpc;
  logic        bad_rd;
  logic        halt_pend;

`ifdef FETCH_ALIGN_CHK_EN
  logic err_q, err_d;

  assign rpc       = redirect_pc;
  assign bad_rd    = redirect && (redirect_pc[1:0] != 2'b00);
  assign halt_pend = err_q;
  assign fetch_err = err_q;
  assign err_d     = err_q | (bad_rd && (state_q != S_HALT));

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
`else
  assign rpc       = redirect_pc & 32'hFFFF_FFFC;
  assign bad_rd    = 1'b0;
  assign halt_pend = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    pc4_buf_d  = pc4_buf_q;
    tgt_d      = tgt_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          if (bad_rd) begin
            state_d = S_HALT;
          end else if (redirect) begin
            pc_d = rpc;
          end else begin
            inst_buf_d = imem_rdata;
            pc4_buf_d  = pc_q + 32'd4;
            state_d    = S_READY;
          end
        end else if (redirect) begin
          tgt_d   = rpc;
          state_d = S_KILL;
        end
      end
      // The in-flight result belongs to a squashed path; wait it out, then refetch at the target.
      S_KILL: begin
        if (imem_ack) begin
          if (halt_pend || bad_rd) begin
            state_d = S_HALT;
          end else begin
            pc_d    = redirect ? rpc : tgt_q;
            state_d = S_FETCH;
          end
        end else if (redirect && !halt_pend) begin
          tgt_d = rpc;
        end
      end
      S_READY: begin
        if (bad_rd) begin
          state_d = S_HALT;
        end else if (redirect) begin
          pc_d    = rpc;
          state_d = S_FETCH;
        end else if (nostall) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      inst_buf_q <= 32'h0;
      pc4_buf_q  <= RESET_PC + 32'd4;
      tgt_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
      pc4_buf_q  <= pc4_buf_d;
      tgt_q      <= tgt_d;
    end
  end

  assign inst_valid = (state_q == S_READY);
  assign imem_req   = (state_q == S_FETCH) || (state_q == S_KILL);
  assign fetch_busy = imem_req;
  assign imem_addr  = pc_q;
  assign pc4        = pc4_buf_q;
  assign inst       = inst_valid ? inst_buf_q : 32'h0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed handshake/redirect/wrap steps, then random waits, stalls and redirects vs. a stream model.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        nostall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc4;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_busy;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .rst(rst), .nostall(nostall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc4(pc4), .inst(inst), .inst_valid(inst_valid), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read after the following falling edge.
  task automatic cyc(input logic ns, input logic rd, input logic [31:0] rpc,
                     input logic ack, input logic [31:0] dat);
    nostall = ns; redirect = rd; redirect_pc = rpc; imem_ack = ack; imem_rdata = dat;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] h_inst, h_pc4, exp_pc, t, prev_addr;
    logic        ns, rd, ack, prev_hold;
    int          consumed;

    rst = 1'b0; nostall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req",   {31'd0, imem_req},   32'd1);
    chk("rst_addr",  imem_addr,           32'h0040_0000);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst",  inst,                32'h0);
    chk("rst_pc4",   pc4,                 32'h0040_0004);
    chk("rst_err",   {31'd0, fetch_err},  32'd0);
    chk("rst_busy",  {31'd0, fetch_busy}, 32'd1);

    // Zero-wait fetch at the reset PC
    rst = 1'b1;
    cyc(1, 0, 0, 1, 32'h2008_0005);
    chk("zw_inst",  inst,                32'h2008_0005);
    chk("zw_pc4",   pc4,                 32'h0040_0004);
    chk("zw_valid", {31'd0, inst_valid}, 32'd1);
    chk("zw_req",   {31'd0, imem_req},   32'd0);
    cyc(1, 0, 0, 0, 32'h0);
    chk("zw_next",  imem_addr,           32'h0040_0004);
    chk("zw_bub",   inst,                32'h0);

    // Three wait states
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 32'hBAD0_0000);
      chk("ws_valid", {31'd0, inst_valid}, 32'd0);
      chk("ws_inst",  inst,                32'h0);
      chk("ws_addr",  imem_addr,           32'h0040_0004);
    end
    cyc(1, 0, 0, 1, 32'h1111_1111);
    chk("ws_inst_arr", inst, 32'h1111_1111);
    chk("ws_pc4",      pc4,  32'h0040_0008);

    // Stall in READY
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 32'h0);
      chk("st_inst",  inst,                32'h1111_1111);
      chk("st_pc4",   pc4,                 32'h0040_0008);
      chk("st_valid", {31'd0, inst_valid}, 32'd1);
      chk("st_req",   {31'd0, imem_req},   32'd0);
    end
    cyc(1, 0, 0, 0, 32'h0);
    chk("st_adv", imem_addr, 32'h0040_0008);

    // Redirect during an unacked fetch; late data must be dropped
    cyc(1, 1, 32'h0040_0100, 0, 32'h0);
    chk("kill_addr", imem_addr, 32'h0040_0008);
    chk("kill_busy", {31'd0, fetch_busy}, 32'd1);
    cyc(1, 0, 0, 0, 32'h0);
    chk("kill_hold", imem_addr, 32'h0040_0008);
    cyc(1, 0, 0, 1, 32'hDEAD_BEEF);
    chk("kill_valid", {31'd0, inst_valid}, 32'd0);
    chk("kill_tgt",   imem_addr,           32'h0040_0100);
    cyc(1, 0, 0, 1, 32'h0000_000A);
    chk("kill_inst", inst, 32'h0000_000A);
    chk("kill_pc4",  pc4,  32'h0040_0104);

    // PC wrap
    cyc(1, 1, 32'hFFFF_FFFC, 0, 32'h0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 1, 32'h0000_0033);
    chk("wrap_pc4", pc4, 32'h0000_0000);
    cyc(1, 0, 0, 0, 32'h0);
    chk("wrap_next", imem_addr, 32'h0000_0000);

    // Redirect coinciding with an ack in FETCH
    cyc(1, 1, 32'h0040_0200, 1, 32'h0000_0044);
    chk("rdack_valid", {31'd0, inst_valid}, 32'd0);
    chk("rdack_addr",  imem_addr,           32'h0040_0200);

    // Misaligned redirect
    cyc(1, 1, 32'h0040_0102, 0, 32'h0);
`ifdef FETCH_ALIGN_CHK_EN
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    cyc(1, 0, 0, 1, 32'h0000_0055);
    chk("halt_req",   {31'd0, imem_req},   32'd0);
    chk("halt_valid", {31'd0, inst_valid}, 32'd0);
    cyc(1, 1, 32'h0040_0300, 0, 32'h0);
    chk("halt_stay", {31'd0, imem_req},   32'd0);
    chk("halt_err",  {31'd0, fetch_err},  32'd1);
`else
    cyc(1, 0, 0, 1, 32'h0000_0055);
    chk("mis_addr", imem_addr,           32'h0040_0100);
    chk("mis_err",  {31'd0, fetch_err},  32'd0);
`endif

    // Reset beats a simultaneous redirect and ack
    rst = 1'b0;
    cyc(1, 1, 32'h0050_0000, 1, 32'h0000_0099);
    chk("rst2_addr",  imem_addr,           32'h0040_0000);
    chk("rst2_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst2_pc4",   pc4,                 32'h0040_0004);
    chk("rst2_err",   {31'd0, fetch_err},  32'd0);
    rst = 1'b1;

    // Random phase: memory serves mem_word(addr); model tracks the address of the next real instruction.
    exp_pc = 32'h0040_0000; consumed = 0; prev_hold = 1'b0; prev_addr = 32'h0;
    for (int c = 0; c < 600; c++) begin
      if (inst_valid) begin
        chk("rnd_inst", inst, mem_word(exp_pc));
        chk("rnd_pc4",  pc4,  exp_pc + 32'd4);
      end else begin
        chk("rnd_nop", inst, 32'h0);
      end
      chk("rnd_req", {31'd0, imem_req}, {31'd0, ~inst_valid});
      if (prev_hold) chk("rnd_addr_hold", imem_addr, prev_addr);

      ns  = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 9) == 0);
      ack = imem_req && ($urandom_range(0, 2) == 0);
      t   = 32'h0040_0000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
`ifndef FETCH_ALIGN_CHK_EN
      t[1:0] = 2'($urandom_range(0, 3));
`endif
      prev_hold = imem_req && !ack;
      prev_addr = imem_addr;
      if (rd) exp_pc = t & 32'hFFFF_FFFC;
      else if (inst_valid && ns) exp_pc = exp_pc + 32'd4;
      if (inst_valid && ns) consumed++;
      h_inst = inst; h_pc4 = pc4;
      cyc(ns, rd, t, ack, mem_word(imem_addr));
    end
    chk("rnd_progress", {31'd0, consumed >= 40}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
